// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer.
// Frame layout: {addr[ADDR_W-1:0], rw, data[DATA_W-1:0]}, MSB first on mosi.
package spi_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = ADDR_W + 1 + DATA_W;

  localparam logic RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: divides clk by CLK_DIV per sclk half-period.
//   clk, rst_n  : system clock, async active-low reset
//   en          : run the divider; when low, counter and sclk are held cleared
//   sclk        : registered SPI clock, idle low
//   rise_tick   : high in the cycle whose closing clk edge drives sclk high
//   fall_tick   : high in the cycle whose closing clk edge drives sclk low
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] half_cnt;
  logic       half_done;

  // Ticks are decoded from registered state so the controller can act on the
  // same clk edge that toggles sclk (e.g. sample miso as sclk rises).
  assign half_done = en && (half_cnt == HALF_LAST);
  assign rise_tick = half_done && !sclk;
  assign fall_tick = half_done &&  sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (half_done) begin
      half_cnt <= '0;
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: accepts one read/write command per handshake, sends a
// {addr, rw, data} frame MSB first, and reports completion on rsp_valid.
//   clk, rst_n          : system clock, async active-low reset
//   req_valid/req_ready : command handshake; req_ready high only in IDLE
//   req_rw              : 1 = read, 0 = write
//   req_addr, req_wdata : command fields (wdata ignored for reads)
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : read data (0 for writes), held until next rsp_valid
//   busy                : high from accept until req_ready returns
//   sclk, cs, mosi, miso: SPI pins (sclk idle low, cs active low)
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = spi_pkg::ADDR_W,
  parameter int unsigned DATA_W  = spi_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned FBITS = ADDR_W + 1 + DATA_W;
  localparam int unsigned BIT_W = $clog2(FBITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FBITS - 1);
  localparam logic [BIT_W-1:0] RX_FIRST = BIT_W'(ADDR_W + 1);
  localparam logic [7:0]       PH_LAST  = 8'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master_ctrl: CLK_DIV must be in 2..255");
  end

  spi_state_e        state, state_next;
  logic [FBITS-1:0]  tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              rw_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [7:0]        phase_cnt;
  logic              phase_done;
  logic              rise_tick, fall_tick;
  logic              accept;
  logic [FBITS-1:0]  frame;

  logic cs_d, req_ready_d, busy_d, rsp_valid_d;

  assign accept     = req_valid && req_ready;
  assign phase_done = (phase_cnt == PH_LAST);
  assign frame      = {req_addr, req_rw, (req_rw == RW_READ) ? {DATA_W{1'b0}} : req_wdata};

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == ST_SHIFT),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (accept)                            state_next = ST_SETUP;
      ST_SETUP: if (phase_done)                        state_next = ST_SHIFT;
      ST_SHIFT: if (fall_tick && bit_cnt == BIT_LAST)  state_next = ST_HOLD;
      ST_HOLD:  if (phase_done)                        state_next = ST_GAP;
      ST_GAP:   if (phase_done)                        state_next = ST_IDLE;
      default:                                         state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered, so their D-values are decoded from the next state;
  // that puts cs low in the first SETUP cycle and rsp_valid on GAP entry.
  always_comb begin
    cs_d        = !(state_next inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    req_ready_d = (state_next == ST_IDLE);
    busy_d      = (state_next != ST_IDLE);
    rsp_valid_d = (state == ST_HOLD) && (state_next == ST_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs        <= 1'b1;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mosi      <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rw_q      <= 1'b0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
    end else begin
      cs        <= cs_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      rsp_valid <= rsp_valid_d;

      if (state_next != state || state == ST_IDLE || state == ST_SHIFT)
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + 8'd1;

      if (state == ST_IDLE && accept) begin
        tx_shift <= frame;
        rw_q     <= req_rw;
        mosi     <= frame[FBITS-1];
        bit_cnt  <= '0;
        rx_shift <= '0;
      end

      if (state == ST_SHIFT) begin
        // Only the data field carries slave response bits.
        if (rise_tick && bit_cnt >= RX_FIRST)
          rx_shift <= {rx_shift[DATA_W-2:0], miso};
        if (fall_tick) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt != BIT_LAST) begin
            tx_shift <= tx_shift << 1;
            mosi     <= tx_shift[FBITS-2];
          end
        end
      end

      if (rsp_valid_d) begin
        mosi      <= 1'b0;
        rsp_rdata <= (rw_q == RW_READ) ? rx_shift : '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;

  spi_master_ctrl #(
    .CLK_DIV (4),
    .ADDR_W  (7),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: capture mosi on each sclk rise and present the next miso bit.
  // Address/rw bits get a constant 1 so they must not leak into rsp_rdata.
  logic [15:0] cap;
  int          rises;
  logic [7:0]  miso_byte;

  always @(posedge sclk) begin
    cap   = {cap[14:0], mosi};
    rises = rises + 1;
    if (rises >= 8 && rises < 16) miso = miso_byte[15 - rises];
    else                          miso = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Starts at a negedge. k counts cycles after the accept cycle (cycle 0).
  task automatic do_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                        input logic [7:0] mb, input bit hold, input int pulse_k, input int rst_k,
                        output logic [15:0] frame_o, output int rises_o, output int rsp_k,
                        output int rdy_k, output logic [7:0] rdata, output int rsp_n,
                        output int gap_hi);
    int w;
    w = 0;
    while (!req_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", req_ready, 1);
    miso_byte = mb;
    rises     = 0;
    cap       = '0;
    miso      = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    rsp_k  = -1;
    rdy_k  = -1;
    rsp_n  = 0;
    gap_hi = 0;
    rdata  = '0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("cs_low_cycle1", cs, 0);
        chk("busy_cycle1", busy, 1);
        if (!hold) req_valid = 1'b0;
      end
      if (k == pulse_k) begin
        req_valid = 1'b1;
        req_addr  = ~addr;
        req_rw    = ~rw;
        req_wdata = ~wdata;
      end
      if (k == pulse_k + 1) req_valid = 1'b0;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_cs_async", cs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_rdata", rsp_rdata, 0);
        repeat (4) begin
          @(negedge clk);
          if (rsp_valid) rsp_n++;
        end
        rst_n = 1'b1;
        break;
      end
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_k < 0) begin
          rsp_k = k;
          rdata = rsp_rdata;
        end
      end
      if (rsp_k >= 0 && cs) gap_hi++;
      if (req_ready) begin
        rdy_k = k;
        break;
      end
    end
    frame_o = cap;
    rises_o = rises;
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  miso_byte;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[6];

  logic [15:0] f_got;
  int          r_got, rsp_k, rdy_k, rsp_n, gap_hi;
  logic [7:0]  rd_got;

  task automatic check_normal(input string tag, input vec_t v);
    chk({tag, "_frame"}, f_got, v.exp_frame);
    chk({tag, "_rises"}, r_got, 16);
    chk({tag, "_rsp_cycle"}, rsp_k, 137);
    chk({tag, "_rdata"}, rd_got, v.exp_rdata);
    chk({tag, "_ready_cycle"}, rdy_k, 141);
    chk({tag, "_rsp_count"}, rsp_n, 1);
    chk({tag, "_cs_gap"}, gap_hi, 5);
    chk({tag, "_rdata_held"}, rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rw    addr   wdata  miso   frame     rdata
    vecs[0] = '{1'b0, 7'h15, 8'hA5, 8'h00, 16'h2AA5, 8'h00};
    vecs[1] = '{1'b1, 7'h7F, 8'h00, 8'h3C, 16'hFF00, 8'h3C};
    vecs[2] = '{1'b0, 7'h00, 8'hFF, 8'hAA, 16'h00FF, 8'h00};
    vecs[3] = '{1'b1, 7'h2A, 8'h5A, 8'hC3, 16'h5500, 8'hC3};
    vecs[4] = '{1'b0, 7'h41, 8'h3C, 8'hFF, 16'h823C, 8'h00};
    vecs[5] = '{1'b1, 7'h01, 8'hFF, 8'h81, 16'h0300, 8'h81};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    miso      = 1'b1;
    miso_byte = '0;
    rises     = 0;
    cap       = '0;
    repeat (3) @(negedge clk);

    chk("reset_cs", cs, 1);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);

    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_rises", rises, 0);
    chk("idle_cs", cs, 1);
    chk("idle_sclk", sclk, 0);
    chk("idle_req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].miso_byte, 1'b0, -10, -10,
             f_got, r_got, rsp_k, rdy_k, rd_got, rsp_n, gap_hi);
      check_normal($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: req_valid stays high, second accept lands on cycle 141.
    do_txn(vecs[0].rw, vecs[0].addr, vecs[0].wdata, vecs[0].miso_byte, 1'b1, -10, -10,
           f_got, r_got, rsp_k, rdy_k, rd_got, rsp_n, gap_hi);
    check_normal("b2b_first", vecs[0]);
    do_txn(vecs[1].rw, vecs[1].addr, vecs[1].wdata, vecs[1].miso_byte, 1'b0, -10, -10,
           f_got, r_got, rsp_k, rdy_k, rd_got, rsp_n, gap_hi);
    check_normal("b2b_second", vecs[1]);

    // Request pulsed mid-frame with inverted fields must be ignored.
    do_txn(vecs[3].rw, vecs[3].addr, vecs[3].wdata, vecs[3].miso_byte, 1'b0, 40, -10,
           f_got, r_got, rsp_k, rdy_k, rd_got, rsp_n, gap_hi);
    check_normal("midpulse", vecs[3]);

    // Reset during a read, then a normal read afterwards.
    do_txn(vecs[1].rw, vecs[1].addr, vecs[1].wdata, vecs[1].miso_byte, 1'b0, -10, 60,
           f_got, r_got, rsp_k, rdy_k, rd_got, rsp_n, gap_hi);
    chk("abort_rsp_count", rsp_n, 0);
    @(negedge clk);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    do_txn(vecs[5].rw, vecs[5].addr, vecs[5].wdata, vecs[5].miso_byte, 1'b0, -10, -10,
           f_got, r_got, rsp_k, rdy_k, rd_got, rsp_n, gap_hi);
    check_normal("after_abort", vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Host-side sequencer that drives the team's SPI slave (address + data-memory block) over sclk/cs/mosi/miso.
- Accepts one read or write command per handshake and serialises it as a 16-bit frame: 7-bit address, rw bit, 8 data bits.
- Returns read data, or a write completion, on a one-cycle response strobe.
- Sits between the on-chip system bus/test host and the SPI pins.

Parameters:
- CLK_DIV, default 4: clk cycles per sclk half-period. Legal range is 2..255; this is checked at elaboration.
- ADDR_W, default 7: address bits per frame.
- DATA_W, default 8: data bits per frame.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes; held until the next rsp_valid.
- busy  out  1  high from accept until req_ready returns.
- sclk  out  1  SPI clock; idle low.
- cs  out  1  chip select, active low; idle high.
- mosi  out  1  serial out, MSB first.
- miso  in  1  serial in.

Behaviour:
- Reset (async assert, sync-released use):
  - cs=1, sclk=0, mosi=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0.
  - State IDLE; all counters 0.
- All outputs are registered.
- Frame word: {addr[6:0], rw, data[7:0]}, 16 bits, sent MSB first. For reads the data field on mosi is 0.
- States and transitions:
  - IDLE: req_ready=1. On accept (cycle 0), latch the command, drop req_ready, set busy, go to SETUP. cs falls at cycle 1.
  - SETUP: CLK_DIV cycles with cs low and sclk low; mosi already carries bit 15. Then go to SHIFT.
  - SHIFT: 16 bit periods of 2*CLK_DIV cycles each.
    - Bit i starts at cycle S = 1 + CLK_DIV + 2*CLK_DIV*i.
    - mosi updates at S; sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - miso is sampled on the clk edge where sclk rises, only for bits 8..15, shifted MSB first.
    - After bit 15's high half, go to HOLD.
  - HOLD: CLK_DIV cycles with sclk low and cs still low. Then go to GAP.
  - GAP: cs=1 and mosi=0 on entry. rsp_valid=1 for the entry cycle only, with rsp_rdata updated the same cycle. Stay CLK_DIV cycles, then go to IDLE.
- Timing with CLK_DIV=4:
  - accept cycle 0; cs low cycles 1..136; first sclk rise at cycle 9.
  - rsp_valid at cycle 137; req_ready=1 again at cycle 141.
  - General latency from accept to rsp_valid is 1 + 34*CLK_DIV.
- req_valid while req_ready=0 is ignored; the command is not latched and no error is raised.
- Request inputs may change after accept without affecting the frame in flight.
- rsp_valid and accept never coincide, because req_ready=0 throughout GAP.
- Reset asserted mid-frame: outputs take reset values immediately (cs high asynchronously), no rsp_valid is issued, and the partial frame is abandoned.
- miso X/Z during bits 0..7 has no effect on rsp_rdata.

Decomposition:
- Package spi_pkg holds:
  - ADDR_W=7, DATA_W=8, FRAME_BITS=16;
  - RW_READ=1'b1;
  - state encoding IDLE/SETUP/SHIFT/HOLD/GAP as localparams.
- Sub-module spi_clk_gen: half-period divider with an enable input.
  - Outputs a registered sclk.
  - Outputs one-cycle rise_tick and fall_tick pulses.
  - It is cleared whenever the controller is outside SHIFT.
- spi_master_ctrl holds:
  - the FSM;
  - a 4-bit bit counter;
  - a 16-bit tx shifter and an 8-bit rx shifter;
  - the phase counter for SETUP/HOLD/GAP.

Test Plan:
- Reset, then idle: cs=1, sclk=0, req_ready=1, no sclk edges for 100 cycles.
- Write addr=7'h15, wdata=8'hA5 (CLK_DIV=4) -> mosi bits on rising sclk = 0010101_0_10100101; exactly 16 rises; rsp_valid at cycle 137 with rsp_rdata=0; req_ready high at 141.
- Read addr=7'h7F with miso model returning 8'h3C -> frame 1111111_1_00000000 on mosi; rsp_rdata=8'h3C at rsp_valid.
- Back-to-back commands with req_valid held high -> second accept occurs exactly at cycle 141; cs high for ≥CLK_DIV cycles between frames.
- req_valid pulsed mid-frame with changed addr -> ignored; the current frame is unchanged and only one rsp_valid is issued.
- rst_n low at cycle 60 of a read -> cs=1 and sclk=0 in the same cycle; no rsp_valid; the next command completes normally with correct data.
